// File: rtl/spi_reg_bridge_if.sv
// Byte-stream (SPI slave side) and register-bus signals of spi_reg_bridge.
// addr_ovf exists only when SPI_BRIDGE_SAT_EN is defined.
interface spi_reg_bridge_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              spi_busy;
  logic              spi_valid;
  logic [7:0]        spi_rx_data;
  logic              spi_read;
  logic [7:0]        spi_tx_data;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              active;
`ifdef SPI_BRIDGE_SAT_EN
  logic              addr_ovf;

  modport slave (
    input  spi_busy, spi_valid, spi_rx_data, spi_read, reg_rdata,
    output spi_tx_data, reg_addr, reg_wdata, reg_we, reg_re, active, addr_ovf
  );
  modport master (
    output spi_busy, spi_valid, spi_rx_data, spi_read, reg_rdata,
    input  spi_tx_data, reg_addr, reg_wdata, reg_we, reg_re, active, addr_ovf
  );
`else
  modport slave (
    input  spi_busy, spi_valid, spi_rx_data, spi_read, reg_rdata,
    output spi_tx_data, reg_addr, reg_wdata, reg_we, reg_re, active
  );
  modport master (
    output spi_busy, spi_valid, spi_rx_data, spi_read, reg_rdata,
    input  spi_tx_data, reg_addr, reg_wdata, reg_we, reg_re, active
  );
`endif
endinterface

// File: rtl/spi_reg_bridge.sv
// Decodes SPI frames ({rw,addr} command + data bytes) into register-bus accesses with
// address auto-increment. SPI_BRIDGE_SAT_EN: saturate at the top address and flag addr_ovf.
module spi_reg_bridge #(
  parameter int unsigned ADDR_W = 7,
  parameter logic [7:0]  STATUS = 8'hA5
) (
  input logic             clk,
  input logic             rst_n,
  spi_reg_bridge_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WR, S_RD_FETCH, S_RD_CAP, S_RD_HOLD
  } state_t;

  state_t            r_state,    w_state_d;
  logic [ADDR_W-1:0] r_addr,     w_addr_d;
  logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_d;
  logic [7:0]        r_tx,       w_tx_d;
  logic [7:0]        r_wdata,    w_wdata_d;
  logic              r_we,       w_we_d;
  logic              r_re,       w_re_d;
  logic              r_rd_pend,  w_rd_pend_d;
  logic              r_active;
  logic [ADDR_W-1:0] w_addr_inc;

`ifdef SPI_BRIDGE_SAT_EN
  logic r_ovf, w_ovf_d;
  logic w_at_max;

  assign w_at_max   = (r_addr == ADDR_MAX);
  assign w_addr_inc = w_at_max ? r_addr : r_addr + ADDR_W'(1);
`else
  assign w_addr_inc = r_addr + ADDR_W'(1);
`endif

  // Next-state and next-output logic; a frame end overrides every state.
  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_reg_addr_d = r_reg_addr;
    w_tx_d       = r_tx;
    w_wdata_d    = r_wdata;
    w_we_d       = 1'b0;
    w_re_d       = 1'b0;
    w_rd_pend_d  = 1'b0;
`ifdef SPI_BRIDGE_SAT_EN
    w_ovf_d      = r_ovf;
`endif
    if ((r_state != S_IDLE) && !bus.spi_busy) begin
      w_state_d = S_IDLE;
      w_tx_d    = STATUS;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_tx_d = STATUS;
          if (bus.spi_busy) begin
            w_state_d = S_CMD;
`ifdef SPI_BRIDGE_SAT_EN
            w_ovf_d   = 1'b0;
`endif
          end
        end
        S_CMD: begin
          if (bus.spi_valid) begin
            w_addr_d = bus.spi_rx_data[ADDR_W-1:0];
            if (bus.spi_rx_data[7]) begin
              w_state_d    = S_RD_FETCH;
              w_re_d       = 1'b1;
              w_reg_addr_d = bus.spi_rx_data[ADDR_W-1:0];
            end else begin
              w_state_d = S_WR;
            end
          end
        end
        S_WR: begin
          if (bus.spi_valid) begin
            w_tx_d   = bus.spi_rx_data;
            w_addr_d = w_addr_inc;
`ifdef SPI_BRIDGE_SAT_EN
            // once the address has run past the top, further bytes are dropped
            if (!r_ovf) begin
              w_we_d       = 1'b1;
              w_wdata_d    = bus.spi_rx_data;
              w_reg_addr_d = r_addr;
            end
            if (w_at_max) w_ovf_d = 1'b1;
`else
            w_we_d       = 1'b1;
            w_wdata_d    = bus.spi_rx_data;
            w_reg_addr_d = r_addr;
`endif
          end
        end
        S_RD_FETCH: w_state_d = S_RD_CAP;
        S_RD_CAP: begin
          w_tx_d    = bus.reg_rdata;
          w_state_d = S_RD_HOLD;
        end
        S_RD_HOLD: begin
          // wait one cycle after spi_read so the loaded byte stays stable, then prefetch
          if (r_rd_pend) begin
`ifdef SPI_BRIDGE_SAT_EN
            if (w_at_max) begin
              w_ovf_d = 1'b1;
              w_tx_d  = STATUS;
            end else begin
              w_addr_d     = w_addr_inc;
              w_reg_addr_d = w_addr_inc;
              w_re_d       = 1'b1;
              w_state_d    = S_RD_FETCH;
            end
`else
            w_addr_d     = w_addr_inc;
            w_reg_addr_d = w_addr_inc;
            w_re_d       = 1'b1;
            w_state_d    = S_RD_FETCH;
`endif
          end else if (bus.spi_read) begin
            w_rd_pend_d = 1'b1;
          end
        end
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_reg_addr <= '0;
      r_tx       <= STATUS;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_active   <= 1'b0;
`ifdef SPI_BRIDGE_SAT_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_reg_addr <= w_reg_addr_d;
      r_tx       <= w_tx_d;
      r_wdata    <= w_wdata_d;
      r_we       <= w_we_d;
      r_re       <= w_re_d;
      r_rd_pend  <= w_rd_pend_d;
      r_active   <= (w_state_d != S_IDLE);
`ifdef SPI_BRIDGE_SAT_EN
      r_ovf      <= w_ovf_d;
`endif
    end
  end

  assign bus.spi_tx_data = r_tx;
  assign bus.reg_addr    = r_reg_addr;
  assign bus.reg_wdata   = r_wdata;
  assign bus.reg_we      = r_we;
  assign bus.reg_re      = r_re;
  assign bus.active      = r_active;
`ifdef SPI_BRIDGE_SAT_EN
  assign bus.addr_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: frame-level reference model (expected strobes, MISO bytes,
// overflow flag) against a per-cycle checker, plus literal checks of the directed frames.
module tb_spi_reg_bridge;

  localparam int unsigned ADDR_W = 7;
  localparam int          AMAX   = (1 << ADDR_W) - 1;
  localparam logic [7:0]  STATUS = 8'hA5;
`ifdef SPI_BRIDGE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_bridge #(.ADDR_W(ADDR_W), .STATUS(STATUS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } xfer_t;

  xfer_t      exp_wr[$];
  xfer_t      exp_rd[$];
  int         exp_miso[$];
  int         log_wr[$];
  int         log_rd[$];
  int         log_miso[$];
  logic [7:0] mdl_mem [0:AMAX];
  logic [7:0] rf_mem  [0:AMAX];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         eof_req = 1'b0;
  bit         exp_ovf = 1'b0;
  bit         prev_busy = 1'b0;
  bit         prev_re = 1'b0;
  bit         hold_pend = 1'b0;
  int         hold_exp = 0;
  xfer_t      e;
  int         w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic chk_log(input string nm, input int got[$], input int want[$]);
    chk({nm, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) chk(nm, got[i], want[i]);
  endtask

  // Per-cycle checker; also acts as the register file behind reg_rdata.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_we", int'(bus.reg_we), 0);
      chk("rst_re", int'(bus.reg_re), 0);
      chk("rst_active", int'(bus.active), 0);
      bus.reg_rdata = 8'h00;
      prev_busy = 1'b0;
      prev_re   = 1'b0;
      hold_pend = 1'b0;
    end else begin
      chk("active", int'(bus.active), int'(prev_busy));
      prev_busy = bus.spi_busy;
      if (bus.reg_we) begin
        chk("we_expected", int'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("we_addr", int'(bus.reg_addr), e.addr);
          chk("we_data", int'(bus.reg_wdata), e.data);
          chk("we_cycle", cyc, e.cyc);
        end
        rf_mem[bus.reg_addr] = bus.reg_wdata;
        log_wr.push_back((int'(bus.reg_addr) << 8) | int'(bus.reg_wdata));
      end
      if (bus.reg_re) begin
        chk("re_expected", int'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          e = exp_rd.pop_front();
          chk("re_addr", int'(bus.reg_addr), e.addr);
          chk("re_cycle", cyc, e.cyc);
        end
        log_rd.push_back(int'(bus.reg_addr));
        bus.reg_rdata = rf_mem[bus.reg_addr];
      end else if (!prev_re) begin
        bus.reg_rdata = 8'($urandom);
      end
      prev_re = bus.reg_re;
      if (bus.spi_read) begin
        chk("miso_expected", int'(exp_miso.size() != 0), 1);
        if (exp_miso.size() != 0) begin
          w = exp_miso.pop_front();
          chk("miso", int'(bus.spi_tx_data), w);
          hold_exp  = w;
          hold_pend = 1'b1;
        end
        log_miso.push_back(int'(bus.spi_tx_data));
      end else if (hold_pend) begin
        chk("miso_hold", int'(bus.spi_tx_data), hold_exp);
        hold_pend = 1'b0;
      end
      if (eof_req) begin
        chk("eof_tx", int'(bus.spi_tx_data), int'(STATUS));
        chk("eof_wr_left", exp_wr.size(), 0);
        chk("eof_rd_left", exp_rd.size(), 0);
        chk("eof_miso_left", exp_miso.size(), 0);
`ifdef SPI_BRIDGE_SAT_EN
        chk("eof_ovf", int'(bus.addr_ovf), int'(exp_ovf));
`endif
        exp_wr.delete();
        exp_rd.delete();
        exp_miso.delete();
        eof_req = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int v);
    bus.spi_rx_data = b;
    bus.spi_valid   = 1'b1;
    v = cyc;
    tick(1);
    bus.spi_valid   = 1'b0;
    bus.spi_rx_data = 8'($urandom);
  endtask

  task automatic load_byte(input int want, output int r);
    exp_miso.push_back(want);
    bus.spi_read = 1'b1;
    r = cyc;
    tick(1);
    bus.spi_read = 1'b0;
  endtask

  task automatic push_x(input bit is_wr, input int addr, input int data, input int c);
    xfer_t x;
    x.addr = addr;
    x.data = data;
    x.cyc  = c;
    if (is_wr) exp_wr.push_back(x);
    else       exp_rd.push_back(x);
  endtask

  // One frame: command, n complete bytes, optionally a started-but-unfinished byte.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] d [8], input int n,
                           input bit partial);
    int base, v, r, a;
    bit rd, ovf;
    base = int'(cmd) & AMAX;
    rd   = cmd[7];
    ovf  = 1'b0;
    bus.spi_busy = 1'b1;
    tick(1 + int'($urandom_range(0, 1)));
    load_byte(int'(STATUS), r);
    tick(int'($urandom_range(3, 8)));
    send_byte(cmd, v);
    if (rd) push_x(1'b0, base, 0, v + 1);
    for (int k = 1; k <= n + int'(partial); k++) begin
      tick(int'($urandom_range(4, 6)));
      a = base + k - 1;
      if (rd) begin
        load_byte((SAT && a > AMAX) ? int'(STATUS) : int'(mdl_mem[a & AMAX]), r);
        if (SAT && a + 1 > AMAX) ovf = 1'b1;
        else push_x(1'b0, (a + 1) & AMAX, 0, r + 2);
      end else begin
        load_byte((k == 1) ? int'(STATUS) : int'(d[k-2]), r);
      end
      if (k <= n) begin
        tick(int'($urandom_range(8, 14)));
        if (rd) begin
          send_byte(8'($urandom), v);
        end else begin
          send_byte(d[k-1], v);
          if (!(SAT && a > AMAX)) begin
            push_x(1'b1, a & AMAX, int'(d[k-1]), v + 1);
            mdl_mem[a & AMAX] = d[k-1];
          end
          if (SAT && a >= AMAX) ovf = 1'b1;
        end
      end
    end
    tick(6);
    bus.spi_busy = 1'b0;
    tick(2);
    exp_ovf = ovf;
    eof_req = 1'b1;
    tick(1 + int'($urandom_range(0, 2)));
  endtask

  task automatic clear_logs();
    log_wr.delete();
    log_rd.delete();
    log_miso.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dat [8];
    logic [7:0] cmd;
    int         want[$];
    int         v;
    bus.spi_busy    = 1'b0;
    bus.spi_valid   = 1'b0;
    bus.spi_rx_data = 8'h00;
    bus.spi_read    = 1'b0;
    for (int i = 0; i <= AMAX; i++) begin
      mdl_mem[i] = 8'($urandom);
      rf_mem[i]  = mdl_mem[i];
    end
    tick(2);
    chk("reset_tx", int'(bus.spi_tx_data), 32'hA5);
    chk("reset_addr", int'(bus.reg_addr), 0);
    chk("reset_wdata", int'(bus.reg_wdata), 0);
`ifdef SPI_BRIDGE_SAT_EN
    chk("reset_ovf", int'(bus.addr_ovf), 0);
`endif
    rst_n = 1'b1;
    tick(3);

    // write burst
    dat = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_logs();
    run_frame(8'h05, dat, 3, 1'b0);
    want = '{32'h0511, 32'h0622, 32'h0733};
    chk_log("wb_we", log_wr, want);
    chk("wb_re_count", log_rd.size(), 0);

    // read burst
    mdl_mem[16] = 8'hAB; rf_mem[16] = 8'hAB;
    mdl_mem[17] = 8'hCD; rf_mem[17] = 8'hCD;
    clear_logs();
    run_frame(8'h90, dat, 2, 1'b0);
    want = '{32'h10, 32'h11, 32'h12};
    chk_log("rb_re", log_rd, want);
    want = '{32'hA5, 32'hAB, 32'hCD};
    chk_log("rb_miso", log_miso, want);
    chk("rb_we_count", log_wr.size(), 0);

    // address wrap / saturation at the top
    dat = '{8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_logs();
    run_frame(8'h7F, dat, 2, 1'b0);
`ifdef SPI_BRIDGE_SAT_EN
    want = '{32'h7F5A};
    chk("wrap_ovf", int'(bus.addr_ovf), 1);
`else
    want = '{32'h7F5A, 32'h00C3};
`endif
    chk_log("wrap_we", log_wr, want);

    // abort inside the first data byte, then a normal frame
    clear_logs();
    run_frame(8'h20, dat, 0, 1'b1);
    chk("abort_we_count", log_wr.size(), 0);
    dat = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_logs();
    run_frame(8'h21, dat, 1, 1'b0);
    want = '{32'h2177};
    chk_log("after_abort_we", log_wr, want);

    // command-only read frame
    clear_logs();
    run_frame(8'h83, dat, 0, 1'b0);
    want = '{32'h03};
    chk_log("cmdonly_re", log_rd, want);
    chk("cmdonly_we_count", log_wr.size(), 0);
    chk("cmdonly_tx", int'(bus.spi_tx_data), 32'hA5);

    // reset while holding read data
    bus.spi_busy = 1'b1;
    tick(2);
    send_byte(8'h90, v);
    push_x(1'b0, 16, 0, v + 1);
    tick(6);
    chk("pre_reset_tx", int'(bus.spi_tx_data), 32'hAB);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(bus.spi_tx_data), 32'hA5);
    chk("midrst_addr", int'(bus.reg_addr), 0);
    chk("midrst_wdata", int'(bus.reg_wdata), 0);
    chk("midrst_active", int'(bus.active), 0);
    chk("midrst_re", int'(bus.reg_re), 0);
    bus.spi_busy = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_rd_left", exp_rd.size(), 0);

    // randomized frames
    for (int f = 0; f < 60; f++) begin
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) cmd[ADDR_W-1:0] = ADDR_W'(AMAX - int'($urandom_range(0, 3)));
      for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
      run_frame(cmd, dat, int'($urandom_range(0, 5)), ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
